// File: rtl/banked_ram_pkg.sv
// -----------------------------------------------------------------------------
// banked_ram_pkg
// Shared types and helpers for banked_pixel_ram and its ram_bank instances.
//   clear_state_t : states of the zero-fill sequencer
//   bank_bits()   : number of low address bits that select a bank
//   row_bits()    : number of high address bits that select a row within a bank
//   addr_bank()   : bank index of a word address
//   addr_row()    : row index of a word address
// The helpers take a 32-bit address; callers zero-extend and size-cast.
// -----------------------------------------------------------------------------
package banked_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clear_state_t;

  function automatic int bank_bits(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 0;
  endfunction

  function automatic int row_bits(input int addr_width, input int num_banks);
    return addr_width - bank_bits(num_banks);
  endfunction

  // num_banks is a power of two, so the mask keeps exactly the bank bits.
  function automatic int unsigned addr_bank(input logic [31:0] addr, input int num_banks);
    return addr & (num_banks - 1);
  endfunction

  function automatic int unsigned addr_row(input logic [31:0] addr, input int num_banks);
    return addr >> bank_bits(num_banks);
  endfunction

endpackage

// File: rtl/ram_bank.sv
// -----------------------------------------------------------------------------
// ram_bank
// Simple dual-port memory bank, one write port and one read port, with a
// registered (1-cycle) read. A read and write to the same row in the same
// cycle return the new write data. Contents are never reset.
// Ports:
//   clock        : clock, all logic on posedge
//   we/waddr/wdata : write enable, row, data
//   re/raddr     : read enable, row
//   rdata        : read data, valid the cycle after re; holds when re is low
// -----------------------------------------------------------------------------
module ram_bank #(
  parameter int ROW_BITS   = 14,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ROW_BITS-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ROW_BITS-1:0]   raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ROW_BITS];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      // Write-first: forward the incoming word instead of the stale array value.
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/banked_pixel_ram.sv
// -----------------------------------------------------------------------------
// banked_pixel_ram
// Address-interleaved multi-port pixel memory. NUM_BANKS banks, each with a
// round-robin arbiter choosing one of NUM_RD_PORTS read requests per cycle,
// plus a zero-fill sequencer that clears one row in every bank per cycle.
// Ports:
//   clock, reset          : clock; asynchronous active-high control reset
//   wr_valid/wr_ready     : write handshake (wr_ready = !busy)
//   wr_addr, wr_data      : write address and pixel
//   rd_valid/rd_ready     : per-port read request / combinational grant
//   rd_addr               : packed read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   rsp_valid, rsp_data   : per-port response, RD_LATENCY cycles after grant
//   clear_req             : start zero-fill (ignored unless idle)
//   busy, clear_done      : fill in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module banked_pixel_ram
  import banked_ram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_BANKS    = 4,
  parameter int NUM_RD_PORTS = 4,
  parameter int RD_LATENCY   = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic [NUM_RD_PORTS-1:0]            rd_valid,
  output logic [NUM_RD_PORTS-1:0]            rd_ready,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD_PORTS-1:0]            rsp_valid,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rsp_data,
  input  logic                               clear_req,
  output logic                               busy,
  output logic                               clear_done
);

  localparam int BANK_BITS = bank_bits(NUM_BANKS);
  localparam int ROW_BITS  = row_bits(ADDR_WIDTH, NUM_BANKS);
  localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int PORT_W    = (NUM_RD_PORTS > 1) ? $clog2(NUM_RD_PORTS) : 1;

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  clear_state_t        state;
  logic [ROW_BITS-1:0] row_cnt;
  logic                busy_reg;
  logic                done_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      row_cnt  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_reg <= 1'b0;
          if (clear_req) begin
            state    <= CLEAR;
            row_cnt  <= '0;
            busy_reg <= 1'b1;
          end
        end
        CLEAR: begin
          row_cnt <= row_cnt + 1'b1;
          if (row_cnt == '1) begin
            state    <= DONE;
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
          end
        end
        DONE: begin
          done_reg <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
          done_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_reg;
  assign clear_done = done_reg;
  assign wr_ready   = !busy_reg;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [BANK_W-1:0]     wr_bank;
  logic [ROW_BITS-1:0]   wr_row;
  logic                  wr_fire;
  logic [BANK_W-1:0]     port_bank  [NUM_RD_PORTS];
  logic [ROW_BITS-1:0]   port_row   [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0] bank_grant [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_q     [NUM_BANKS];

  assign wr_bank = BANK_W'(addr_bank(32'(wr_addr), NUM_BANKS));
  assign wr_row  = ROW_BITS'(addr_row(32'(wr_addr), NUM_BANKS));
  assign wr_fire = wr_valid && !busy_reg;

  // ---------------------------------------------------------------------------
  // Banks with their round-robin arbiters
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [NUM_RD_PORTS-1:0] req;
    logic [NUM_RD_PORTS-1:0] grant;
    logic [PORT_W-1:0]       ptr_reg;
    logic [PORT_W-1:0]       sel;
    logic                    found;
    int                      idx;
    logic                    we;
    logic [ROW_BITS-1:0]     waddr;
    logic [DATA_WIDTH-1:0]   wdata;

    // Scan ports starting at the pointer; first requester wins.
    always_comb begin
      req   = '0;
      grant = '0;
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        req[p] = rd_valid[p] && !busy_reg && (port_bank[p] == BANK_W'(gi));
      end
      for (int i = 0; i < NUM_RD_PORTS; i++) begin
        idx = int'(ptr_reg) + i;
        if (idx >= NUM_RD_PORTS) begin
          idx = idx - NUM_RD_PORTS;
        end
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          sel        = PORT_W'(idx);
          found      = 1'b1;
        end
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        ptr_reg <= '0;
      end else if (found) begin
        ptr_reg <= (sel == PORT_W'(NUM_RD_PORTS - 1)) ? '0 : sel + 1'b1;
      end
    end

    // The clear sequencer owns every bank's write port while busy.
    assign we    = busy_reg || (wr_fire && (wr_bank == BANK_W'(gi)));
    assign waddr = busy_reg ? row_cnt : wr_row;
    assign wdata = busy_reg ? '0 : wr_data;

    ram_bank #(
      .ROW_BITS   (ROW_BITS),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clock (clock),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .re    (found),
      .raddr (port_row[sel]),
      .rdata (bank_q[gi])
    );

    assign bank_grant[gi] = grant;
  end

  // ---------------------------------------------------------------------------
  // Per-port grant collection and response routing
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_port
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rdy;
    logic                  valid1_reg;
    logic [BANK_W-1:0]     tag1_reg;
    logic [DATA_WIDTH-1:0] data1;

    assign addr          = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign port_bank[gi] = BANK_W'(addr_bank(32'(addr), NUM_BANKS));
    assign port_row[gi]  = ROW_BITS'(addr_row(32'(addr), NUM_BANKS));

    always_comb begin
      rdy = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        rdy = rdy | bank_grant[b][gi];
      end
    end
    assign rd_ready[gi] = rdy;

    // Remember which bank serves this port so the following cycle can pick its output.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        valid1_reg <= 1'b0;
        tag1_reg   <= '0;
      end else begin
        valid1_reg <= rdy;
        tag1_reg   <= port_bank[gi];
      end
    end

    assign data1 = valid1_reg ? bank_q[tag1_reg] : '0;

    if (RD_LATENCY == 2) begin : g_oreg
      logic                  v_reg;
      logic [DATA_WIDTH-1:0] d_reg;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          v_reg <= 1'b0;
          d_reg <= '0;
        end else begin
          v_reg <= valid1_reg;
          d_reg <= data1;
        end
      end
      assign rsp_valid[gi]                          = v_reg;
      assign rsp_data[gi*DATA_WIDTH +: DATA_WIDTH] = d_reg;
    end else begin : g_direct
      assign rsp_valid[gi]                          = valid1_reg;
      assign rsp_data[gi*DATA_WIDTH +: DATA_WIDTH] = data1;
    end
  end

endmodule

// File: tb/tb_banked_pixel_ram.sv
// -----------------------------------------------------------------------------
// tb_banked_pixel_ram
// Directed self-checking bench for banked_pixel_ram with default parameters.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_banked_pixel_ram;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int NB  = 4;
  localparam int NP  = 4;
  localparam int LAT = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  logic [NP-1:0]    rd_valid = '0;
  logic [NP-1:0]    rd_ready;
  logic [NP*AW-1:0] rd_addr = '0;
  logic [NP-1:0]    rsp_valid;
  logic [NP*DW-1:0] rsp_data;
  logic             clear_req = 1'b0;
  logic             busy;
  logic             clear_done;

  int n_cmp = 0;
  int n_err = 0;

  banked_pixel_ram #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .NUM_BANKS    (NB),
    .NUM_RD_PORTS (NP),
    .RD_LATENCY   (LAT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_addr    (rd_addr),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_done (clear_done)
  );

  always #5 clock = ~clock;

  // Single uncontended write, one cycle.
  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clock);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clock);
    wr_valid = 1'b0;
    $display("write addr=%h data=%h", a, d);
  endtask

  // Single read on one port; returns the grant, response strobe and data.
  task automatic read_word(input int p, input logic [AW-1:0] a,
                           output logic g, output logic v, output logic [DW-1:0] d);
    @(negedge clock);
    rd_valid    = '0;
    rd_valid[p] = 1'b1;
    rd_addr[p*AW +: AW] = a;
    #1 g = rd_ready[p];
    @(negedge clock);
    rd_valid = '0;
    repeat (LAT-1) @(negedge clock);
    #1;
    v = rsp_valid[p];
    d = rsp_data[p*DW +: DW];
    $display("read port=%0d addr=%h grant=%b valid=%b data=%h", p, a, g, v, d);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    #1;
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    n_cmp++; if (rd_ready !== '0) begin n_err++; $display("FAIL reset_rd_ready got %b want 0", rd_ready); end
    n_cmp++; if (rsp_valid !== '0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_data !== '0) begin n_err++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (clear_done !== 1'b0) begin n_err++; $display("FAIL reset_clear_done got %b want 0", clear_done); end
    @(negedge clock);
    reset = 1'b0;
    $display("reset released");
  endtask

  // All four ports hit bank 0: grants rotate p0..p3, one per cycle.
  task automatic test_round_robin();
    logic [NP-1:0] exp_rdy;
    logic [NP-1:0] exp_v;
    write_word(16'h0004, 8'h37);
    for (int c = 0; c < 4 + LAT; c++) begin
      @(negedge clock);
      if (c == 0) begin
        rd_valid = '1;
        for (int p = 0; p < NP; p++) rd_addr[p*AW +: AW] = 16'h0004;
      end else if (c <= 4) begin
        rd_valid[c-1] = 1'b0;
      end
      #1;
      exp_rdy = '0;
      if (c < 4) exp_rdy[c] = 1'b1;
      exp_v = '0;
      if (c >= LAT && c - LAT < 4) exp_v[c-LAT] = 1'b1;
      n_cmp++; if (rd_ready !== exp_rdy) begin n_err++; $display("FAIL rr_grant cycle %0d got %b want %b", c, rd_ready, exp_rdy); end
      n_cmp++; if (rsp_valid !== exp_v) begin n_err++; $display("FAIL rr_rsp_valid cycle %0d got %b want %b", c, rsp_valid, exp_v); end
      if (c >= LAT && c - LAT < 4) begin
        n_cmp++;
        if (rsp_data[(c-LAT)*DW +: DW] !== 8'h37) begin
          n_err++; $display("FAIL rr_rsp_data port %0d got %h want 37", c - LAT, rsp_data[(c-LAT)*DW +: DW]);
        end
      end
      $display("rr cycle %0d ready=%b rsp_valid=%b", c, rd_ready, rsp_valid);
    end
  endtask

  // Four ports, four distinct banks, one cycle.
  task automatic test_parallel_read();
    logic [DW-1:0] exp_d [NP];
    exp_d[0] = 8'hAA; exp_d[1] = 8'h55; exp_d[2] = 8'hFF; exp_d[3] = 8'h00;
    for (int p = 0; p < NP; p++) write_word(AW'(p), exp_d[p]);
    @(negedge clock);
    rd_valid = '1;
    for (int p = 0; p < NP; p++) rd_addr[p*AW +: AW] = AW'(p);
    #1;
    n_cmp++; if (rd_ready !== 4'hF) begin n_err++; $display("FAIL par_grant got %b want 1111", rd_ready); end
    @(negedge clock);
    rd_valid = '0;
    repeat (LAT-1) @(negedge clock);
    #1;
    n_cmp++; if (rsp_valid !== 4'hF) begin n_err++; $display("FAIL par_rsp_valid got %b want 1111", rsp_valid); end
    for (int p = 0; p < NP; p++) begin
      n_cmp++;
      if (rsp_data[p*DW +: DW] !== exp_d[p]) begin
        n_err++; $display("FAIL par_rsp_data port %0d got %h want %h", p, rsp_data[p*DW +: DW], exp_d[p]);
      end
    end
    $display("parallel read rsp_data=%h", rsp_data);
  endtask

  // Same-cycle write and read of 0x0500 returns the new value.
  task automatic test_write_first();
    logic g, v;
    logic [DW-1:0] d;
    write_word(16'h0500, 8'h11);
    @(negedge clock);
    wr_valid = 1'b1; wr_addr = 16'h0500; wr_data = 8'hCC;
    rd_valid = 4'b0010; rd_addr[1*AW +: AW] = 16'h0500;
    #1;
    n_cmp++; if (rd_ready !== 4'b0010) begin n_err++; $display("FAIL wf_grant got %b want 0010", rd_ready); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL wf_wr_ready got %b want 1", wr_ready); end
    @(negedge clock);
    wr_valid = 1'b0; rd_valid = '0;
    repeat (LAT-1) @(negedge clock);
    #1;
    n_cmp++; if (rsp_valid[1] !== 1'b1) begin n_err++; $display("FAIL wf_rsp_valid got %b want 1", rsp_valid[1]); end
    n_cmp++; if (rsp_data[1*DW +: DW] !== 8'hCC) begin n_err++; $display("FAIL wf_rsp_data got %h want cc", rsp_data[1*DW +: DW]); end
    $display("write-first read data=%h", rsp_data[1*DW +: DW]);
    read_word(1, 16'h0500, g, v, d);
    n_cmp++; if (d !== 8'hCC) begin n_err++; $display("FAIL wf_stored got %h want cc", d); end
  endtask

  // Top-of-memory addresses do not alias onto the bottom.
  task automatic test_boundary();
    logic g, v;
    logic [DW-1:0] d;
    write_word(16'hFFFF, 8'hEE);
    write_word(16'hFFF0, 8'hEF);
    read_word(0, 16'hFFFF, g, v, d);
    n_cmp++; if (g !== 1'b1 || v !== 1'b1) begin n_err++; $display("FAIL bnd_ffff_hs got g=%b v=%b want 1 1", g, v); end
    n_cmp++; if (d !== 8'hEE) begin n_err++; $display("FAIL bnd_ffff got %h want ee", d); end
    read_word(1, 16'hFFF0, g, v, d);
    n_cmp++; if (d !== 8'hEF) begin n_err++; $display("FAIL bnd_fff0 got %h want ef", d); end
    read_word(2, 16'h0000, g, v, d);
    n_cmp++; if (d !== 8'hAA) begin n_err++; $display("FAIL bnd_0000 got %h want aa", d); end
  endtask

  task automatic test_clear();
    logic g, v;
    logic [DW-1:0] d;
    int busy_cnt;
    int pulses;
    bit blocked_ok;
    bit seen_end;
    write_word(16'h1234, 8'h5A);
    @(negedge clock);
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    // Hold requests up the whole time to prove nothing is accepted while busy.
    wr_valid = 1'b1; wr_addr = 16'h0100; wr_data = 8'h00;
    rd_valid = '1;
    for (int p = 0; p < NP; p++) rd_addr[p*AW +: AW] = AW'(p);
    busy_cnt = 0; pulses = 0; blocked_ok = 1'b1; seen_end = 1'b0;
    for (int i = 0; i < 20000 && !seen_end; i++) begin
      #1;
      if (busy) begin
        busy_cnt++;
        if (wr_ready !== 1'b0 || rd_ready !== '0) blocked_ok = 1'b0;
        if (clear_done) pulses++;
      end else begin
        seen_end = 1'b1;
        wr_valid = 1'b0;
        rd_valid = '0;
      end
      if (!seen_end) @(negedge clock);
    end
    n_cmp++; if (seen_end !== 1'b1) begin n_err++; $display("FAIL clr_timeout got busy=%b want 0 within 20000 cycles", busy); end
    n_cmp++; if (busy_cnt !== 16384) begin n_err++; $display("FAIL clr_busy_cycles got %0d want 16384", busy_cnt); end
    n_cmp++; if (blocked_ok !== 1'b1) begin n_err++; $display("FAIL clr_ready_low got a ready while busy want none"); end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL clr_early_done got %0d pulses want 0", pulses); end
    n_cmp++; if (clear_done !== 1'b1) begin n_err++; $display("FAIL clr_done_pulse got %b want 1", clear_done); end
    @(negedge clock);
    #1;
    n_cmp++; if (clear_done !== 1'b0) begin n_err++; $display("FAIL clr_done_width got %b want 0", clear_done); end
    $display("clear finished after %0d busy cycles", busy_cnt);
    read_word(0, 16'h0000, g, v, d);
    n_cmp++; if (d !== 8'h00 || v !== 1'b1) begin n_err++; $display("FAIL clr_0000 got %h v=%b want 00 1", d, v); end
    read_word(1, 16'h1234, g, v, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL clr_1234 got %h want 00", d); end
    read_word(2, 16'hFFFF, g, v, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL clr_ffff got %h want 00", d); end
  endtask

  task automatic test_reset_mid_clear();
    logic g, v;
    logic [DW-1:0] d;
    // In-flight read is dropped by reset.
    @(negedge clock);
    rd_valid = 4'b0001; rd_addr[0 +: AW] = 16'h0000;
    @(negedge clock);
    rd_valid = '0;
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== '0) begin n_err++; $display("FAIL rst_inflight_now got %b want 0", rsp_valid); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    n_cmp++; if (rsp_valid !== '0) begin n_err++; $display("FAIL rst_inflight_after got %b want 0", rsp_valid); end

    write_word(16'h0000, 8'h11);   // row 0
    write_word(16'h018F, 8'h22);   // row 99, bank 3
    write_word(16'h0190, 8'h33);   // row 100
    write_word(16'h0320, 8'h44);   // row 200
    @(negedge clock);
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    repeat (100) @(negedge clock);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before got %b want 1", busy); end
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy_after got %b want 0", busy); end
    n_cmp++; if (rsp_valid !== '0) begin n_err++; $display("FAIL mid_rsp_valid got %b want 0", rsp_valid); end
    @(negedge clock);
    reset = 1'b0;
    $display("reset during clear");
    read_word(0, 16'h0000, g, v, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL mid_row0 got %h want 00", d); end
    read_word(3, 16'h018F, g, v, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL mid_row99 got %h want 00", d); end
    read_word(0, 16'h0190, g, v, d);
    n_cmp++; if (d !== 8'h33) begin n_err++; $display("FAIL mid_row100 got %h want 33", d); end
    read_word(0, 16'h0320, g, v, d);
    n_cmp++; if (d !== 8'h44) begin n_err++; $display("FAIL mid_row200 got %h want 44", d); end

    // A fresh clear starts from row 0 again: cut it after 5 rows.
    write_word(16'h0000, 8'h55);   // row 0
    write_word(16'h0004, 8'h66);   // row 1
    write_word(16'h0028, 8'h77);   // row 10
    @(negedge clock);
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    repeat (5) @(negedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    read_word(0, 16'h0000, g, v, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL restart_row0 got %h want 00", d); end
    read_word(1, 16'h0004, g, v, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL restart_row1 got %h want 00", d); end
    read_word(2, 16'h0028, g, v, d);
    n_cmp++; if (d !== 8'h77) begin n_err++; $display("FAIL restart_row10 got %h want 77", d); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_parallel_read();
    test_write_first();
    test_boundary();
    test_clear();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/banked_pixel_ram.md
# banked_pixel_ram

Parametrised multi-port pixel memory for the parallel bilinear interpolation datapath. It replaces the single-read-port dual-port RAM with NUM_BANKS address-interleaved banks and NUM_RD_PORTS independent read ports, so all four neighbours of a sample can be fetched in one cycle. It also adds per-bank round-robin conflict arbitration, write-first read-during-write bypass, and a hardware clear sequencer. It sits between the frame loader (write side) and the interpolation lanes (read side).

## Interface
- ADDR_WIDTH, 16, word address width; total depth 2^ADDR_WIDTH
- DATA_WIDTH, 8, pixel width
- NUM_BANKS, 4, power of two, 1..16; bank = addr[BANK_BITS-1:0]
- NUM_RD_PORTS, 4, number of read ports, 1..8
- RD_LATENCY, 2, 1 or 2; 2 adds an output register
- clock  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-high; clears control state only, never memory contents
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- rd_valid  in  NUM_RD_PORTS  per-port read request
- rd_ready  out  NUM_RD_PORTS  per-port grant
- rd_addr  in  NUM_RD_PORTS*ADDR_WIDTH  packed; port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
- rsp_valid  out  NUM_RD_PORTS  per-port response strobe
- rsp_data  out  NUM_RD_PORTS*DATA_WIDTH  packed, same packing as rd_addr
- clear_req  in  1  start zero-fill
- busy  out  1  clear in progress
- clear_done  out  1  one-cycle pulse at end of clear

## Operation
- Address split: bank = addr[BANK_BITS-1:0], row = addr[ADDR_WIDTH-1:BANK_BITS].
- Each bank has one write port and one read port. Writes never conflict with reads.
- Read arbitration: each cycle, each bank grants at most one port among those with rd_valid whose address maps to it.
  - Selection is round-robin. The per-bank pointer starts at port 0 after reset and moves to granted+1 (mod NUM_RD_PORTS) after each grant.
  - rd_ready[p] is combinational from rd_valid and rd_addr.
  - A port that is not granted holds rd_valid and rd_addr stable until granted.
- Write-first: a read granted in the same cycle as an accepted write to the same address returns the new wr_data.
- wr_ready = !busy. All rd_ready are 0 while busy.
- Clear FSM states:
  - IDLE: on clear_req, go to CLEAR. row counter = 0, busy = 1.
  - CLEAR: write 0 to row counter in every bank in parallel and increment. At the last row, go to DONE.
  - DONE: clear_done = 1 for one cycle, busy = 0, then IDLE.
  - clear_req outside IDLE is ignored.
- Reads already in the pipeline when clear starts still complete.

## Timing
- Read accepted at edge N produces rsp_valid[p] = 1 with rsp_data[p] valid in the cycle after edge N+RD_LATENCY-1. For RD_LATENCY = 2, the response is visible after edge N+1 and sampled at edge N+2.
- Full throughput: every port is granted every cycle when all ports hit distinct banks.
- Response order per port equals request order. No reordering across ports is needed, because latency is fixed.
- Write visible to a read granted at edge N+1 or later, plus same-cycle bypass as above.
- Clear duration: 2^(ADDR_WIDTH-BANK_BITS) cycles in CLEAR, plus 1 cycle in DONE.
- Reset values: wr_ready = 1, rd_ready = 0, rsp_valid = 0, rsp_data = 0, busy = 0, clear_done = 0. FSM = IDLE, all RR pointers = 0.
- Reset mid-clear: return to IDLE immediately, leave memory partially cleared, drop in-flight responses with no rsp_valid.
- Address 2^ADDR_WIDTH-1 maps to the last bank, last row. There is no wrap or aliasing.

## Structure
- Package banked_ram_pkg:
  - clear_state_t enum (IDLE, CLEAR, DONE)
  - BANK_BITS / ROW_BITS localparam functions
  - bank/row extraction functions
- Sub-module ram_bank: simple dual-port, write-first, ROW_BITS x DATA_WIDTH, 1-cycle read, inferable as M10K.
- Top level contains:
  - NUM_BANKS ram_bank instances
  - per-bank RR arbiters
  - per-port grant-to-bank routing and response mux, pipelined with a bank-select tag
  - optional output register
  - clear FSM

## Test plan
- Write 0xAA, 0x55, 0xFF, 0x00 to addresses 0..3. Ports 0..3 read addresses 0..3 in the same cycle -> all rd_ready = 1, and RD_LATENCY cycles later rsp_data = AA, 55, FF, 00.
- Ports 0..3 all read address 0x0004 (bank 0) for 4 cycles -> exactly one grant per cycle in order p0, p1, p2, p3. Each receives the stored value. The other rd_ready stay 0 until granted.
- Write 0xCC to 0x0500 while port 1 reads 0x0500 in the same cycle -> rsp_data[1] = 0xCC (write-first).
- Write 0xEE to 0xFFFF and 0xEF to 0xFFF0, then read both -> 0xEE and 0xEF returned, and address 0x0000 is unchanged.
- Fill the memory with nonzero data, then pulse clear_req:
  - busy stays high for 16384 cycles (defaults), then clear_done pulses once.
  - wr_ready and rd_ready are 0 throughout.
  - Reads of 0x0000, 0x1234 and 0xFFFF then return 0x00.
- Assert reset 100 cycles into a clear -> busy = 0 and rsp_valid = 0 immediately. Rows 0..99 read 0x00, row 200 keeps its old data, and a new clear_req restarts from row 0.
